// File: rtl/ctrl_fsm_pkg.sv
// ctrl_fsm_pkg: shared types and encodings for the multicycle main control FSM.
//   state_t  - 4-bit FSM state enum (FETCH..UNKNOWN)
//   OP_*     - instr[27:26] opcode classes
//   SRCA_*, SRCB_*, RES_* - datapath mux select encodings
//   ctrl_t   - bundle of control outputs produced by ctrl_fsm_outdec
//   retires  - true when the current state hands a finished instruction back to FETCH
package ctrl_fsm_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXECUTER = 4'd2,
    EXECUTEI = 4'd3,
    ALUWB    = 4'd4,
    MEMADR   = 4'd5,
    MEMRD    = 4'd6,
    MEMWB    = 4'd7,
    MEMWR    = 4'd8,
    BRANCH   = 4'd9,
    UNKNOWN  = 4'd10
  } state_t;

  localparam logic [1:0] OP_DP    = 2'b00;
  localparam logic [1:0] OP_MEM   = 2'b01;
  localparam logic [1:0] OP_BR    = 2'b10;
  localparam logic [1:0] OP_UNDEF = 2'b11;

  localparam logic [1:0] SRCA_RN     = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_ALUOUT = 2'b10;

  localparam logic [1:0] SRCB_RM     = 2'b00;
  localparam logic [1:0] SRCB_EXTIMM = 2'b01;
  localparam logic [1:0] SRCB_FOUR   = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  typedef struct packed {
    logic       irwrite;
    logic       adrsrc;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       aluop;
    logic       pcs;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       undef;
  } ctrl_t;

  // A store only completes once memory has accepted it; UNKNOWN never retires.
  function automatic logic retires(input state_t s, input logic memrdy);
    case (s)
      ALUWB, MEMWB, BRANCH: return 1'b1;
      MEMWR:                return memrdy;
      default:              return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_fsm_outdec.sv
// ctrl_fsm_outdec: pure state -> control decode for ctrl_fsm.
// Ports:
//   state  in  state_t  current FSM state
//   active in  1        0 while reset is held; strobes forced 0, selects take FETCH values
//   memrdy in  1        memory handshake (gates IRWrite/PCS in FETCH)
//   ctrl   out ctrl_t   decoded selects and unconditioned strobes
module ctrl_fsm_outdec
  import ctrl_fsm_pkg::*;
(
  input  state_t state,
  input  logic   active,
  input  logic   memrdy,
  output ctrl_t  ctrl
);

  state_t st;

  always_comb begin
    // Holding reset presents the FETCH selects; FETCH's strobes are then
    // killed through the active gate, so nothing from an aborted state leaks.
    st   = active ? state : FETCH;
    ctrl = '0;
    case (st)
      FETCH: begin
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.irwrite   = memrdy & active;
        ctrl.pcs       = memrdy & active;
      end
      DECODE: begin
        ctrl.alusrca   = SRCA_PC;
        ctrl.alusrcb   = SRCB_FOUR;
        ctrl.resultsrc = RES_ALURESULT;
      end
      EXECUTER: begin
        ctrl.alusrca = SRCA_RN;
        ctrl.alusrcb = SRCB_RM;
        ctrl.aluop   = 1'b1;
      end
      EXECUTEI: begin
        ctrl.alusrca = SRCA_RN;
        ctrl.alusrcb = SRCB_EXTIMM;
        ctrl.aluop   = 1'b1;
      end
      ALUWB: begin
        ctrl.resultsrc = RES_ALUOUT;
        ctrl.regw      = 1'b1;
      end
      MEMADR: begin
        ctrl.alusrca = SRCA_RN;
        ctrl.alusrcb = SRCB_EXTIMM;
      end
      MEMRD: begin
        ctrl.adrsrc = 1'b1;
      end
      MEMWB: begin
        ctrl.resultsrc = RES_DATA;
        ctrl.regw      = 1'b1;
      end
      MEMWR: begin
        ctrl.adrsrc = 1'b1;
        ctrl.memw   = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca   = SRCA_ALUOUT;
        ctrl.alusrcb   = SRCB_EXTIMM;
        ctrl.resultsrc = RES_ALURESULT;
        ctrl.branch    = 1'b1;
      end
      UNKNOWN: begin
        ctrl.undef = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/ctrl_fsm.sv
// ctrl_fsm: multicycle main control FSM (fetch/decode/execute) feeding condlogic.
// Optional feature macro: CTRL_FSM_PERF_EN enables the CycleCnt/InstrCnt counters;
// without it the counter ports are tied to 0 and no counter flops exist.
// Ports:
//   clk, reset (sync, active-low)
//   Op[1:0], Funct[5:0]  instruction fields; MemRdy memory handshake
//   IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, ALUOp  datapath controls
//   PCS, RegW, MemW, Branch  unconditioned strobes; Undef pulse on Op=11
//   CycleCnt, InstrCnt [PERF_W-1:0]  performance counters
module ctrl_fsm
  import ctrl_fsm_pkg::*;
#(
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        Op,
  input  logic [5:0]        Funct,
  input  logic              MemRdy,
  output logic              IRWrite,
  output logic              AdrSrc,
  output logic [1:0]        ALUSrcA,
  output logic [1:0]        ALUSrcB,
  output logic [1:0]        ResultSrc,
  output logic              ALUOp,
  output logic              PCS,
  output logic              RegW,
  output logic              MemW,
  output logic              Branch,
  output logic              Undef,
  output logic [PERF_W-1:0] CycleCnt,
  output logic [PERF_W-1:0] InstrCnt
);

  state_t state;
  ctrl_t  ctrl;
  logic   unused_funct;

  // Only I (bit 5) and L (bit 0) steer sequencing.
  assign unused_funct = ^Funct[4:1];

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:    if (MemRdy) state <= DECODE;
        DECODE: begin
          case (Op)
            OP_DP:   state <= Funct[5] ? EXECUTEI : EXECUTER;
            OP_MEM:  state <= MEMADR;
            OP_BR:   state <= BRANCH;
            default: state <= UNKNOWN;
          endcase
        end
        EXECUTER: state <= ALUWB;
        EXECUTEI: state <= ALUWB;
        ALUWB:    state <= FETCH;
        MEMADR:   state <= Funct[0] ? MEMRD : MEMWR;
        MEMRD:    if (MemRdy) state <= MEMWB;
        MEMWB:    state <= FETCH;
        MEMWR:    if (MemRdy) state <= FETCH;
        BRANCH:   state <= FETCH;
        UNKNOWN:  state <= FETCH;
        default:  state <= FETCH;  // unreachable encodings recover here
      endcase
    end
  end

  ctrl_fsm_outdec u_outdec (
    .state  (state),
    .active (reset),
    .memrdy (MemRdy),
    .ctrl   (ctrl)
  );

  assign IRWrite   = ctrl.irwrite;
  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign ALUOp     = ctrl.aluop;
  assign PCS       = ctrl.pcs;
  assign RegW      = ctrl.regw;
  assign MemW      = ctrl.memw;
  assign Branch    = ctrl.branch;
  assign Undef     = ctrl.undef;

`ifdef CTRL_FSM_PERF_EN
  logic [PERF_W-1:0] cycle_cnt;
  logic [PERF_W-1:0] instr_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
      instr_cnt <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + PERF_W'(1);
      if (retires(state, MemRdy)) instr_cnt <= instr_cnt + PERF_W'(1);
    end
  end

  assign CycleCnt = cycle_cnt;
  assign InstrCnt = instr_cnt;
`else
  assign CycleCnt = '0;
  assign InstrCnt = '0;
`endif

endmodule
